// File: rtl/system86_pkg.sv
// Shared definitions for the system86 colour PROM loader: load states,
// memory depths and field positions within the 3R red/green word.
package system86_pkg;

    localparam int ADDR_W      = 9;
    localparam int R_DEPTH_DEF = 512;
    localparam int S_DEPTH_DEF = 512;

    // 3R word layout: green in the upper nibble, red in the lower nibble
    localparam int GREEN_MSB = 7;
    localparam int RED_MSB   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_R,
        ST_LOAD_S,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/prom_write_port.sv
// Registered write stage for one colour lookup RAM: a transfer on one edge
// becomes a single-cycle write strobe with its address and data on the next.
module prom_write_port
    import system86_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK_6MD,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              we
);

    // NOTE: state is updated with non-blocking assignments so every flop in the
    // design samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK_6MD) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
            we      <= 1'b0;
        end else begin
            we <= write;
            if (write) begin
                wr_addr <= addr;
                wr_data <= data;
            end
        end
    end

endmodule

// File: rtl/videogen_prom_loader.sv
// Streams palette bytes into the writable 3R (red/green) and 3S (blue) lookup
// RAMs, verifies a trailing additive checksum and holds video off meanwhile.
module videogen_prom_loader
    import system86_pkg::*;
#(
    parameter int R_DEPTH     = R_DEPTH_DEF,
    parameter int S_DEPTH     = S_DEPTH_DEF,
    parameter int CHECKSUM_EN = 1
) (
    input  logic              CLK_6MD,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prom_3r_wr_addr,
    output logic [7:0]        prom_3r_wr_data,
    output logic              prom_3r_we,
    output logic [ADDR_W-1:0] prom_3s_wr_addr,
    output logic [3:0]        prom_3s_wr_data,
    output logic              prom_3s_we,
    output logic              video_hold,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              nib_err
);

    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(R_DEPTH - 1);
    localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(S_DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        sum;

    logic       xfer;
    logic       write_r;
    logic       write_s;
    logic [7:0] r_word;

    assign xfer    = in_valid && in_ready;
    assign write_r = xfer && (state == ST_LOAD_R);
    assign write_s = xfer && (state == ST_LOAD_S);
    assign r_word  = {in_data[GREEN_MSB -: 4], in_data[RED_MSB -: 4]};

    prom_write_port #(.DATA_W(8)) u_port_3r (
        .CLK_6MD (CLK_6MD),
        .reset   (reset),
        .write   (write_r),
        .addr    (cnt),
        .data    (r_word),
        .wr_addr (prom_3r_wr_addr),
        .wr_data (prom_3r_wr_data),
        .we      (prom_3r_we)
    );

    prom_write_port #(.DATA_W(4)) u_port_3s (
        .CLK_6MD (CLK_6MD),
        .reset   (reset),
        .write   (write_s),
        .addr    (cnt),
        .data    (in_data[3:0]),
        .wr_addr (prom_3s_wr_addr),
        .wr_data (prom_3s_wr_data),
        .we      (prom_3s_we)
    );

    // in_ready, busy and video_hold are registered alongside the state so they
    // change on exactly the edge that enters or leaves the loading states.
    always_ff @(posedge CLK_6MD) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sum        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            video_hold <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            nib_err    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state      <= ST_LOAD_R;
                        cnt        <= '0;
                        sum        <= '0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        nib_err    <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        video_hold <= 1'b1;
                    end
                end
                ST_LOAD_R: begin
                    if (xfer) begin
                        sum <= sum + in_data;
                        if (cnt == R_LAST) begin
                            cnt   <= '0;
                            state <= ST_LOAD_S;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_S: begin
                    if (xfer) begin
                        // the full byte enters the sum even though only blue is stored
                        sum <= sum + in_data;
                        if (in_data[7:4] != 4'd0) nib_err <= 1'b1;
                        if (cnt == S_LAST) begin
                            cnt <= '0;
                            if (CHECKSUM_EN != 0) begin
                                state <= ST_CHECK;
                            end else begin
                                state      <= ST_DONE;
                                done       <= 1'b1;
                                in_ready   <= 1'b0;
                                busy       <= 1'b0;
                                video_hold <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        in_ready   <= 1'b0;
                        busy       <= 1'b0;
                        video_hold <= 1'b0;
                        if (in_data == sum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_videogen_prom_loader.sv
// Bench for videogen_prom_loader: a byte-count model of the loader checks two
// builds (with and without checksum) every cycle, plus memory-image checks.
module tb_videogen_prom_loader;

    localparam int RD = 512;
    localparam int SD = 512;
    localparam int NB = RD + SD + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, in_valid;
    logic [7:0] in_data;

    logic       a_ready, a_we_r, a_we_s, a_hold, a_busy, a_done, a_fail, a_nib;
    logic [8:0] a_addr_r, a_addr_s;
    logic [7:0] a_data_r;
    logic [3:0] a_data_s;
    logic       b_ready, b_we_r, b_we_s, b_hold, b_busy, b_done, b_fail, b_nib;
    logic [8:0] b_addr_r, b_addr_s;
    logic [7:0] b_data_r;
    logic [3:0] b_data_s;

    videogen_prom_loader #(.CHECKSUM_EN(1)) dut_a (
        .CLK_6MD(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(a_ready),
        .prom_3r_wr_addr(a_addr_r), .prom_3r_wr_data(a_data_r), .prom_3r_we(a_we_r),
        .prom_3s_wr_addr(a_addr_s), .prom_3s_wr_data(a_data_s), .prom_3s_we(a_we_s),
        .video_hold(a_hold), .busy(a_busy), .done(a_done), .fail(a_fail), .nib_err(a_nib)
    );

    videogen_prom_loader #(.CHECKSUM_EN(0)) dut_b (
        .CLK_6MD(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(b_ready),
        .prom_3r_wr_addr(b_addr_r), .prom_3r_wr_data(b_data_r), .prom_3r_we(b_we_r),
        .prom_3s_wr_addr(b_addr_s), .prom_3s_wr_data(b_data_s), .prom_3s_we(b_we_s),
        .video_hold(b_hold), .busy(b_busy), .done(b_done), .fail(b_fail), .nib_err(b_nib)
    );

    typedef struct packed {
        logic       in_ready, we_r, we_s, hold, busy, done, fail, nib;
        logic [8:0] addr_r, addr_s;
        logic [7:0] data_r;
        logic [3:0] data_s;
    } obs_t;

    // Loader expectation in terms of bytes accepted since start
    typedef struct packed {
        bit         active, rst, we_r, we_s, done, fail, nib;
        int         n;
        logic [7:0] sum;
        logic [8:0] addr_r, addr_s;
        logic [7:0] data_r;
        logic [3:0] data_s;
    } mdl_t;

    obs_t oa, ob;
    assign oa = {a_ready, a_we_r, a_we_s, a_hold, a_busy, a_done, a_fail, a_nib,
                 a_addr_r, a_addr_s, a_data_r, a_data_s};
    assign ob = {b_ready, b_we_r, b_we_s, b_hold, b_busy, b_done, b_fail, b_nib,
                 b_addr_r, b_addr_s, b_data_r, b_data_s};

    int   total = 0;
    int   bad = 0;
    mdl_t ma, mb;
    bit   armed = 1'b0;
    bit   v_edge = 1'b0;

    logic [7:0] stream [NB];
    bit         ck_good;
    logic [7:0] dm_r [2][RD];
    logic [3:0] dm_s [2][SD];
    bit         wr_r [2][RD];
    bit         wr_s [2][SD];
    int         wcnt_r [2];
    int         wcnt_s [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input bit ck_en, input bit rst,
                                  input bit st, input bit v, input logic [7:0] d);
        mdl_t r;
        r = m;
        r.rst  = 1'b0;
        r.we_r = 1'b0;
        r.we_s = 1'b0;
        if (rst) begin
            r     = '0;
            r.rst = 1'b1;
        end else if (!m.active) begin
            if (st) begin
                r.active = 1'b1;
                r.n      = 0;
                r.sum    = 8'd0;
                r.done   = 1'b0;
                r.fail   = 1'b0;
                r.nib    = 1'b0;
            end
        end else if (v) begin
            if (m.n < RD) begin
                r.we_r   = 1'b1;
                r.addr_r = 9'(m.n);
                r.data_r = d;
                r.sum    = 8'((int'(m.sum) + int'(d)) % 256);
            end else if (m.n < RD + SD) begin
                r.we_s   = 1'b1;
                r.addr_s = 9'(m.n - RD);
                r.data_s = d[3:0];
                r.sum    = 8'((int'(m.sum) + int'(d)) % 256);
                if (d >= 8'd16) r.nib = 1'b1;
            end else begin
                r.active = 1'b0;
                r.done   = (d == m.sum);
                r.fail   = (d != m.sum);
            end
            r.n = m.n + 1;
            if (r.n == RD + SD && !ck_en) begin
                r.active = 1'b0;
                r.done   = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        v_edge = in_valid;
        ma = step(ma, 1'b1, reset, start, in_valid, in_data);
        mb = step(mb, 1'b0, reset, start, in_valid, in_data);
        armed = 1'b1;
    end

    task automatic cmp(input string t, input obs_t o, input mdl_t m);
        check({t, ".in_ready"}, o.in_ready, m.active);
        check({t, ".busy"}, o.busy, m.active);
        check({t, ".video_hold"}, o.hold, m.active);
        check({t, ".done"}, o.done, m.done);
        check({t, ".fail"}, o.fail, m.fail);
        check({t, ".nib_err"}, o.nib, m.nib);
        check({t, ".we_3r"}, o.we_r, m.we_r);
        check({t, ".we_3s"}, o.we_s, m.we_s);
        check({t, ".one_we"}, o.we_r & o.we_s, 0);
        if (!v_edge) check({t, ".idle_strobe"}, o.we_r | o.we_s, 0);
        if (m.we_r || m.rst) begin
            check({t, ".addr_3r"}, o.addr_r, m.addr_r);
            check({t, ".data_3r"}, o.data_r, m.data_r);
        end
        if (m.we_s || m.rst) begin
            check({t, ".addr_3s"}, o.addr_s, m.addr_s);
            check({t, ".data_3s"}, o.data_s, m.data_s);
        end
    endtask

    task automatic capture(input int k, input obs_t o);
        if (o.we_r === 1'b1) begin
            dm_r[k][o.addr_r] = o.data_r;
            wr_r[k][o.addr_r] = 1'b1;
            wcnt_r[k]++;
        end
        if (o.we_s === 1'b1) begin
            dm_s[k][o.addr_s] = o.data_s;
            wr_s[k][o.addr_s] = 1'b1;
            wcnt_s[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("a", oa, ma);
            cmp("b", ob, mb);
            capture(0, oa);
            capture(1, ob);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern stream: 3R byte = addr[7:0], 3S byte = addr[3:0]; or random bytes
    task automatic make_stream(input bit rnd, input logic [7:0] ck_xor,
                               input int ov_idx, input logic [7:0] ov_val);
        int s;
        s = 0;
        for (int i = 0; i < RD + SD; i++) begin
            if (rnd)         stream[i] = 8'($urandom_range(255, 0));
            else if (i < RD) stream[i] = 8'(i % 256);
            else             stream[i] = 8'((i - RD) % 16);
            if (i == ov_idx) stream[i] = ov_val;
            s = (s + int'(stream[i])) % 256;
        end
        stream[RD + SD] = 8'(s) ^ ck_xor;
        ck_good = (ck_xor == 8'd0);
    endtask

    task automatic check_images();
        for (int k = 0; k < 2; k++) begin
            check("write_count_3r", wcnt_r[k], RD);
            check("write_count_3s", wcnt_s[k], SD);
            for (int i = 0; i < RD; i++)
                check("image_3r", {wr_r[k][i], dm_r[k][i]}, {1'b1, stream[i]});
            for (int i = 0; i < SD; i++)
                check("image_3s", {wr_s[k][i], dm_s[k][i]}, {1'b1, stream[RD + i][3:0]});
        end
    endtask

    task automatic run_load(input bit gaps, input int rst_at, input int start_at);
        int run;
        for (int k = 0; k < 2; k++) begin
            wcnt_r[k] = 0;
            wcnt_s[k] = 0;
            for (int i = 0; i < RD; i++) wr_r[k][i] = 1'b0;
            for (int i = 0; i < SD; i++) wr_s[k][i] = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            run = 0;
            while (gaps && run < 8 && $urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                tick();
                run++;
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            start    = (i == start_at);
            reset    = (i == rst_at);
            tick();
            start = 1'b0;
            if (i == rst_at) begin
                reset    = 1'b0;
                in_valid = 1'b0;
                check("reset_mid.hold", a_hold, 0);
                check("reset_mid.ready", a_ready, 0);
                check("reset_mid.we_3r", a_we_r, 0);
                return;
            end
            if (!gaps && i == RD + SD - 1) begin
                check("nock.done_at_last_write", b_done, 1);
                check("nock.last_strobe", b_we_s, 1);
                check("nock.ready_low", b_ready, 0);
                check("nock.hold_low", b_hold, 0);
                check("ck.not_done_yet", a_done, 0);
                check("ck.hold_still", a_hold, 1);
            end
            if (!gaps && i == RD + SD) begin
                check("ck.done_cycle", a_done, ck_good);
                check("ck.fail_cycle", a_fail, !ck_good);
                check("ck.hold_fall", a_hold, 0);
                check("ck.ready_low", a_ready, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        check_images();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset.in_ready", a_ready, 0);
        check("reset.we", {a_we_r, a_we_s, b_we_r, b_we_s}, 0);
        check("reset.addr", {a_addr_r, a_addr_s}, 0);
        check("reset.data", {a_data_r, a_data_s}, 0);
        check("reset.flags", {a_hold, a_busy, a_done, a_fail, a_nib}, 0);

        // back-to-back pattern load, correct checksum
        make_stream(1'b0, 8'h00, -1, 8'h00);
        check("pattern_checksum", stream[NB - 1], 8'h00);
        run_load(1'b0, -1, -1);
        check("t1.done", a_done, 1);

        // wrong checksum still performs every write
        make_stream(1'b0, 8'h01, -1, 8'h00);
        check("bad_checksum_byte", stream[NB - 1], 8'h01);
        run_load(1'b0, -1, -1);
        check("t2.fail", a_fail, 1);
        check("t2.done", a_done, 0);
        check("t2.nock_done", b_done, 1);

        // non-zero high nibble in a 3S byte
        make_stream(1'b0, 8'h00, RD + 7, 8'hA5);
        check("a5_checksum", stream[NB - 1], 8'h9E);
        run_load(1'b0, -1, -1);
        check("t3.blue7", dm_s[0][7], 4'h5);
        check("t3.nib_err", a_nib, 1);
        check("t3.done", a_done, 1);

        // random data with random in_valid gaps
        make_stream(1'b1, 8'h00, -1, 8'h00);
        run_load(1'b1, -1, -1);
        check("t4.done", a_done, 1);

        // pattern with gaps must give the same images as back-to-back
        make_stream(1'b0, 8'h00, -1, 8'h00);
        run_load(1'b1, -1, -1);
        check("t5.done", a_done, 1);

        // reset at transfer 300, then a clean reload
        run_load(1'b0, 300, -1);
        tick();
        check("t6.idle_done", a_done, 0);
        run_load(1'b0, -1, -1);
        check("t6.reload_done", a_done, 1);

        // start pulsed during LOAD_S is ignored
        run_load(1'b0, -1, 700);
        check("t7.done", a_done, 1);
        check("t7.fail", a_fail, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
